// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the data-memory sequencer: state encoding,
// RISC-V load/store funct3 codes and the byte-lane base mask.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    LAST  = 3'd3,
    RESP  = 3'd4
  } seqState_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Lane mask before shifting by the byte offset; undefined sizes give no lanes.
  function automatic logic [3:0] baseMask(input logic [2:0] func3);
    logic [3:0] mask;
    case (func3[1:0])
      2'd0:    mask = 4'h1;
      2'd1:    mask = 4'h3;
      2'd2:    mask = 4'hF;
      default: mask = 4'h0;
    endcase
    return mask;
  endfunction

  function automatic logic isLegal(input logic isWrite, input logic [2:0] func3);
    logic ok;
    if (isWrite) ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    else         ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                      (func3 == F3_BU) || (func3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load alignment: shifts the {hi,lo} read pair down by the byte
// offset and sign- or zero-extends the selected byte/half/word.
module load_aligner
  import mem_seq_pkg::*;
(
  input  logic [63:0] pair,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] word;

  assign word = 32'(pair >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (func3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_W:    result = word;
      F3_BU:   result = {24'b0, word[7:0]};
      F3_HU:   result = {16'b0, word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sequencer.sv
// MEM-stage to byte-enabled data RAM sequencer with registered response.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two RAM beats.
module data_mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int RamAddrWidth = 10
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    reqValid,
  input  logic                    reqWrite,
  input  logic [2:0]              reqFunc3,
  input  logic [AddrWidth-1:0]    reqAddr,
  input  logic [DataWidth-1:0]    reqWdata,
  output logic                    reqReady,
  output logic                    busy,
  output logic                    rspValid,
  output logic [DataWidth-1:0]    rspRdata,
  output logic                    rspFault,
  output logic                    ramEn,
  output logic                    ramWe,
  output logic [3:0]              ramByteEn,
  output logic [RamAddrWidth-1:0] ramAddr,
  output logic [DataWidth-1:0]    ramWdata,
  input  logic [DataWidth-1:0]    ramRdata
);

  seqState_t   state, nextState;
  logic [1:0]  reqOff;
  logic [7:0]  reqMask8;
  logic        reqCross, reqFault;
  logic [63:0] reqShift;
  logic        writeReg, faultReg;
  logic [2:0]  f3Reg;
  logic [1:0]  offReg;
  logic [63:0] alignPair;
  logic [31:0] alignData;
  logic        unusedBits;

  assign reqOff   = reqAddr[1:0];
  assign reqMask8 = {4'b0000, baseMask(reqFunc3)} << reqOff;
  assign reqCross = |reqMask8[7:4];
  assign reqShift = {32'b0, reqWdata} << {reqOff, 3'b000};
  assign reqReady = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef MISALIGN_SPLIT_EN
  logic                    crossReg;
  logic [RamAddrWidth-1:0] wordReg;
  logic [3:0]              hiMaskReg;
  logic [31:0]             hiDataReg, loReg;

  assign reqFault   = !isLegal(reqWrite, reqFunc3);
  assign unusedBits = ^reqAddr[AddrWidth-1:RamAddrWidth+2];
  assign alignPair  = crossReg ? {ramRdata, loReg} : {32'b0, ramRdata};

  // Second-beat context; the first beat's read word arrives while in BEAT1.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      crossReg  <= 1'b0;
      wordReg   <= '0;
      hiMaskReg <= '0;
      hiDataReg <= '0;
      loReg     <= '0;
    end else begin
      if (reqValid && state == IDLE) begin
        crossReg  <= reqCross;
        wordReg   <= reqAddr[RamAddrWidth+1:2];
        hiMaskReg <= reqMask8[7:4];
        hiDataReg <= reqShift[63:32];
      end
      if (state == BEAT1) loReg <= ramRdata;
    end
  end
`else
  assign reqFault   = !isLegal(reqWrite, reqFunc3) || reqCross;
  assign unusedBits = ^{reqAddr[AddrWidth-1:RamAddrWidth+2], reqShift[63:32]};
  assign alignPair  = {32'b0, ramRdata};
`endif

  load_aligner u_align (
    .pair   (alignPair),
    .off    (offReg),
    .func3  (f3Reg),
    .result (alignData)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  // Faults detour through LAST so every response leaves from the same point.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqValid) nextState = reqFault ? LAST : BEAT0;
`ifdef MISALIGN_SPLIT_EN
      BEAT0:   nextState = crossReg ? BEAT1 : LAST;
      BEAT1:   nextState = LAST;
`else
      BEAT0:   nextState = LAST;
`endif
      LAST:    nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      writeReg <= 1'b0;
      faultReg <= 1'b0;
      f3Reg    <= '0;
      offReg   <= '0;
    end else if (reqValid && state == IDLE) begin
      writeReg <= reqWrite;
      faultReg <= reqFault;
      f3Reg    <= reqFunc3;
      offReg   <= reqOff;
    end
  end

  // Outputs are loaded from the upcoming state so each beat is driven for the whole state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ramEn     <= 1'b0;
      ramWe     <= 1'b0;
      ramByteEn <= '0;
      ramAddr   <= '0;
      ramWdata  <= '0;
      rspValid  <= 1'b0;
      rspFault  <= 1'b0;
      rspRdata  <= '0;
    end else begin
      ramEn     <= 1'b0;
      ramWe     <= 1'b0;
      ramByteEn <= '0;
      ramAddr   <= '0;
      ramWdata  <= '0;
      case (nextState)
        BEAT0: begin
          ramEn     <= 1'b1;
          ramWe     <= reqWrite;
          ramAddr   <= reqAddr[RamAddrWidth+1:2];
          ramByteEn <= reqMask8[3:0];
          ramWdata  <= reqShift[31:0];
        end
`ifdef MISALIGN_SPLIT_EN
        BEAT1: begin
          ramEn     <= 1'b1;
          ramWe     <= writeReg;
          ramAddr   <= wordReg + RamAddrWidth'(1);
          ramByteEn <= hiMaskReg;
          ramWdata  <= hiDataReg;
        end
`endif
        default: ;
      endcase
      rspValid <= (nextState == RESP);
      rspFault <= (nextState == RESP) && faultReg;
      rspRdata <= ((nextState == RESP) && !faultReg && !writeReg) ? alignData : '0;
    end
  end

endmodule
